// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_pkg;

   localparam int AW = 5;
   localparam int DW = 32;

   // Register reserved for the stack path; normal producers never write it.
   localparam logic [4:0] STACK_REG = 5'd31;

   // Which producer wins when both request in the same cycle.
   typedef enum logic {
      PRI_MEM = 1'b0,
      PRI_ALU = 1'b1
   } pri_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two producers, the issue stage and the arbiter.
// The slave modport is the arbiter's view; master is the requesters' view.
interface regfile_wb_arbiter_if #(
   parameter int AW = regfile_wb_pkg::AW,
   parameter int DW = regfile_wb_pkg::DW
);

   logic                 alu_valid;
   logic                 alu_ready;
   logic [AW-1:0]        alu_addr;
   logic signed [DW-1:0] alu_data;

   logic                 mem_valid;
   logic                 mem_ready;
   logic [AW-1:0]        mem_addr;
   logic signed [DW-1:0] mem_data;

   logic                 reg_Write;
   logic [AW-1:0]        Write_Address;
   logic signed [DW-1:0] Write_data;
   logic                 r31_drop;

   logic                 issue_valid;
   logic [AW-1:0]        issue_addr;
   logic [AW-1:0]        chk_ra;
   logic [AW-1:0]        chk_rb;
   logic                 hazard_ra;
   logic                 hazard_rb;

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  mem_valid, mem_addr, mem_data,
      input  issue_valid, issue_addr, chk_ra, chk_rb,
      output alu_ready, mem_ready,
      output reg_Write, Write_Address, Write_data, r31_drop,
      output hazard_ra, hazard_rb
   );

   modport master (
      output alu_valid, alu_addr, alu_data,
      output mem_valid, mem_addr, mem_data,
      output issue_valid, issue_addr, chk_ra, chk_rb,
      input  alu_ready, mem_ready,
      input  reg_Write, Write_Address, Write_data, r31_drop,
      input  hazard_ra, hazard_rb
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set at issue, cleared when the
// write-back lands. A same-edge set beats a clear because a newer producer
// of that register is now in flight. The stack register is never tracked.
module regfile_scoreboard
   import regfile_wb_pkg::*;
#(
   parameter int AW = regfile_wb_pkg::AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic          rd_busy_a,
   output logic          rd_busy_b
);

   localparam int               NREG = 1 << AW;
   localparam logic [AW-1:0]    R31  = AW'(STACK_REG);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   // Apply clear first, then set, so a coincident set survives.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      busy_nxt = busy;
      if (clr_en) busy_nxt[clr_addr] = 1'b0;
      if (set_en && set_addr != R31) busy_nxt[set_addr] = 1'b1;
   end

   // Busy vector storage.
   always_ff @(posedge clk) begin
      // NOTE: the busy vector is plain flops, not RAM, so it is reset; a stale bit would stall issue forever.
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end

   // Read ports; R31 and reset both force "not busy".
   always_comb begin
      rd_busy_a = !reset && rd_addr_a != R31 && busy[rd_addr_a];
      rd_busy_b = !reset && rd_addr_b != R31 && busy[rd_addr_b];
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter in front of the 32x32 register file. Shares the single
// write port between the ALU and memory result paths, protects the ALU from
// starvation, filters writes to the stack register, and (when
// REGFILE_WB_SCOREBOARD_EN is defined) tracks in-flight destinations for
// read-after-write hazard detection.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int AW       = regfile_wb_pkg::AW,
   parameter int DW       = regfile_wb_pkg::DW,
   parameter int MAX_WAIT = 4
) (
   input logic                 clk,
   input logic                 reset,
   regfile_wb_arbiter_if.slave bus
);

   localparam int            CW       = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);
   localparam logic [AW-1:0] R31      = AW'(STACK_REG);

   pri_state_e    state;
   pri_state_e    state_nxt;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_cnt_nxt;
   logic          alu_xfer;
   logic          mem_xfer;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_data;

   assign alu_xfer = bus.alu_valid && bus.alu_ready;
   assign mem_xfer = bus.mem_valid && bus.mem_ready;
   assign win_addr = alu_xfer ? bus.alu_addr : bus.mem_addr;
   assign win_data = alu_xfer ? bus.alu_data : bus.mem_data;

   // Priority state register.
   always_ff @(posedge clk) begin
      if (reset) state <= PRI_MEM;
      else       state <= state_nxt;
   end

   // Next priority: hand the ALU priority once it has waited MAX_WAIT cycles,
   // return it to memory as soon as the ALU is served or withdraws.
   always_comb begin
      state_nxt = state;
      case (state)
         PRI_MEM: if (wait_cnt_nxt == WAIT_SAT)       state_nxt = PRI_ALU;
         PRI_ALU: if (alu_xfer || !bus.alu_valid)     state_nxt = PRI_MEM;
         default:                                     state_nxt = PRI_MEM;
      endcase
   end

   // Grants: an uncontested requester always wins; contention follows state.
   always_comb begin
      bus.alu_ready = 1'b0;
      bus.mem_ready = 1'b0;
      if (!reset) begin
         if (bus.alu_valid && bus.mem_valid) begin
            bus.alu_ready = (state == PRI_ALU);
            bus.mem_ready = (state == PRI_MEM);
         end else begin
            bus.alu_ready = bus.alu_valid;
            bus.mem_ready = bus.mem_valid;
         end
      end
   end

   // Starvation counter: counts refused ALU cycles, saturating at MAX_WAIT.
   always_comb begin
      wait_cnt_nxt = wait_cnt;
      if (!bus.alu_valid || alu_xfer) wait_cnt_nxt = '0;
      else if (wait_cnt != WAIT_SAT)  wait_cnt_nxt = wait_cnt + 1'b1;
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (reset) wait_cnt <= '0;
      else       wait_cnt <= wait_cnt_nxt;
   end

   // Registered write port; stack-register writes are swallowed and flagged.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.reg_Write     <= 1'b0;
         bus.Write_Address <= '0;
         bus.Write_data    <= '0;
         bus.r31_drop      <= 1'b0;
      end else begin
         bus.reg_Write <= 1'b0;
         bus.r31_drop  <= 1'b0;
         if (alu_xfer || mem_xfer) begin
            if (win_addr == R31) begin
               bus.r31_drop <= 1'b1;
            end else begin
               bus.reg_Write     <= 1'b1;
               bus.Write_Address <= win_addr;
               bus.Write_data    <= win_data;
            end
         end
      end
   end

`ifdef REGFILE_WB_SCOREBOARD_EN
   regfile_scoreboard #(
      .AW (AW)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .set_en    (bus.issue_valid),
      .set_addr  (bus.issue_addr),
      .clr_en    (bus.reg_Write),
      .clr_addr  (bus.Write_Address),
      .rd_addr_a (bus.chk_ra),
      .rd_addr_b (bus.chk_rb),
      .rd_busy_a (bus.hazard_ra),
      .rd_busy_b (bus.hazard_rb)
   );
`else
   // Without the scoreboard the issue-side inputs are intentionally ignored.
   logic unused_issue;
   assign unused_issue  = ^{bus.issue_valid, bus.issue_addr, bus.chk_ra, bus.chk_rb};
   assign bus.hazard_ra = 1'b0;
   assign bus.hazard_rb = 1'b0;
`endif

endmodule
